or_in_collector: RTL

Upstream packing stage for the OR reduction block. Accepts one BIT-wide word per cycle over a valid/ready handshake, assembles NUMBER_INPUT words into the flat NUMBER_INPUT*BIT bus the OR stage consumes, and presents the completed bundle with its own valid/ready handshake. Unfilled lanes are zero, which is the OR identity, so a partial bundle reduces correctly.

---
 rtl/or_collect_pkg.sv | 18 +
 rtl/or_collect_ctrl.sv | 74 +++++++
 rtl/or_in_collector.sv | 71 +++++++
 3 files changed

// File: rtl/or_collect_pkg.sv
// Shared types and constants for the OR-reduction input collector.
// Optional flush support is selected with the OR_COLLECT_FLUSH_EN macro.
package or_collect_pkg;

    localparam int BIT_DEF          = 29;
    localparam int NUMBER_INPUT_DEF = 16;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } or_state_e;

    // The counter must reach NUMBER_INPUT itself, hence one bit beyond the lane index.
    function automatic int cnt_width(input int number_input);
        return $clog2(number_input) + 1;
    endfunction

endpackage

// File: rtl/or_collect_ctrl.sv
// Collector FSM and lane counter: FILL accepts words lane by lane, HOLD presents
// the bundle until taken. Flush support depends on OR_COLLECT_FLUSH_EN.
import or_collect_pkg::*;

module or_collect_ctrl #(
    parameter int NUMBER_INPUT = NUMBER_INPUT_DEF,
    parameter int CW           = cnt_width(NUMBER_INPUT_DEF),
    parameter int IW           = $clog2(NUMBER_INPUT_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
`ifdef OR_COLLECT_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          out_ready,
    output logic          in_ready,
    output logic          out_valid,
    output logic          wr_en,
    output logic [IW-1:0] wr_idx,
    output logic          clear,
    output logic [CW-1:0] cnt,
    output or_state_e     state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready may lead valid, and out_valid is held until out_ready.
    or_state_e     state_n;
    logic [CW-1:0] cnt_n;
    logic          accept;

    // in_ready is gated by rst_n so it reads low throughout reset.
    assign in_ready  = rst_n && (state == FILL);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign wr_en     = accept;
    assign wr_idx    = cnt[IW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clear   = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(NUMBER_INPUT - 1)) state_n = HOLD;
                end
`ifdef OR_COLLECT_FLUSH_EN
                if (flush && ((cnt != '0) || accept)) state_n = HOLD;
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = FILL;
                    cnt_n   = '0;
                    clear   = 1'b1;
                end
            end
            default: state_n = FILL;
        endcase
    end

endmodule

// File: rtl/or_in_collector.sv
// Packs BIT-wide words into a NUMBER_INPUT*BIT bus for the OR stage; unfilled
// lanes stay zero. Define OR_COLLECT_FLUSH_EN to add the flush port.
import or_collect_pkg::*;

module or_in_collector #(
    parameter int BIT          = BIT_DEF,
    parameter int NUMBER_INPUT = NUMBER_INPUT_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [BIT-1:0]                       in_data,
`ifdef OR_COLLECT_FLUSH_EN
    input  logic                                 flush,
`endif
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUMBER_INPUT*BIT-1:0]          out_bus,
    output logic [$clog2(NUMBER_INPUT):0]        out_count
);

    localparam int CW = cnt_width(NUMBER_INPUT);
    localparam int IW = $clog2(NUMBER_INPUT);

    logic                        wr_en;
    logic [IW-1:0]               wr_idx;
    logic                        clear;
    logic [CW-1:0]               cnt;
    or_state_e                   state_dbg;
    logic [NUMBER_INPUT*BIT-1:0] bus_q;

    or_collect_ctrl #(
        .NUMBER_INPUT (NUMBER_INPUT),
        .CW           (CW),
        .IW           (IW)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
`ifdef OR_COLLECT_FLUSH_EN
        .flush     (flush),
`endif
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .clear     (clear),
        .cnt       (cnt),
        .state     (state_dbg)
    );

    // Clearing on hand-off restores the OR identity in every lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q <= '0;
        end else if (clear) begin
            bus_q <= '0;
        end else if (wr_en) begin
            bus_q[wr_idx*BIT +: BIT] <= in_data;
        end
    end

    assign out_bus   = bus_q;
    assign out_count = cnt;

    a_valid_tracks_hold: assert property (
        @(posedge clk) disable iff (!rst_n) out_valid == (state_dbg == HOLD));

endmodule
